pong_data_memory: RTL and testbench

PONG_DATA_MEMORY -- requirements
Module: pong_data_memory

---
 rtl/pong_data_memory_if.sv | 11 +
 rtl/pong_data_memory.sv | 94 +++++++++
 tb/tb_pong_data_memory.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pong_data_memory_if.sv
// CPU-side bus of the PONG data memory: combinational read port and synchronous write port.
interface pong_data_memory_if;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output rd_addr, wr_en, wr_addr, wr_data, input rd_data);
  modport slave  (input rd_addr, wr_en, wr_addr, wr_data, output rd_data);
endinterface

// File: rtl/pong_data_memory.sv
// 16x8 PONG data memory with synchronized switch words 13-15 and a
// 4-row LED scanner driven from display words 4-7.
module pong_data_memory #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  pong_data_memory_if.slave   bus,
  input  logic [7:0]          init0_i,
  input  logic [7:0]          init1_i,
  input  logic [7:0]          init2_i,
  input  logic [7:0]          init3_i,
  input  logic [7:0]          init4_i,
  input  logic [7:0]          init5_i,
  input  logic [7:0]          init6_i,
  input  logic [7:0]          init7_i,
  input  logic [7:0]          init8_i,
  input  logic [7:0]          init9_i,
  input  logic [7:0]          init10_i,
  input  logic [7:0]          init11_i,
  input  logic [7:0]          init12_i,
  input  logic [7:0]          init13_i,
  input  logic [7:0]          init14_i,
  input  logic [7:0]          init15_i,
  input  logic [23:0]         sw_raw_i,
  output logic [3:0]          row_sel_o,
  output logic [7:0]          col_out_o
);

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  logic [7:0]  init_w [16];
  logic [7:0]  mem_q  [16];
  logic [7:0]  mem_d  [16];
  logic [23:0] sync1_q, sync2_q;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  row_idx_q, row_idx_d;

  assign init_w[0]  = init0_i;
  assign init_w[1]  = init1_i;
  assign init_w[2]  = init2_i;
  assign init_w[3]  = init3_i;
  assign init_w[4]  = init4_i;
  assign init_w[5]  = init5_i;
  assign init_w[6]  = init6_i;
  assign init_w[7]  = init7_i;
  assign init_w[8]  = init8_i;
  assign init_w[9]  = init9_i;
  assign init_w[10] = init10_i;
  assign init_w[11] = init11_i;
  assign init_w[12] = init12_i;
  assign init_w[13] = init13_i;
  assign init_w[14] = init14_i;
  assign init_w[15] = init15_i;

  // CPU writes only reach words 0-12; words 13-15 are owned by the switch pipeline.
  always_comb begin
    for (int i = 0; i < 16; i++) mem_d[i] = mem_q[i];
    if (bus.wr_en && (bus.wr_addr <= 4'd12)) mem_d[bus.wr_addr] = bus.wr_data;
    mem_d[13] = sync2_q[7:0];
    mem_d[14] = sync2_q[15:8];
    mem_d[15] = sync2_q[23:16];
  end

  always_comb begin
    cnt_d     = cnt_q + 16'd1;
    row_idx_d = row_idx_q;
    if (cnt_q == SCAN_LAST) begin
      cnt_d     = 16'd0;
      row_idx_d = row_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= init_w[i];
      sync1_q   <= '0;
      sync2_q   <= '0;
      cnt_q     <= '0;
      row_idx_q <= '0;
    end else begin
      for (int i = 0; i < 16; i++) mem_q[i] <= mem_d[i];
      sync1_q   <= sw_raw_i;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      row_idx_q <= row_idx_d;
    end
  end

  assign bus.rd_data = mem_q[bus.rd_addr];
  assign row_sel_o   = 4'b0001 << row_idx_q;
  assign col_out_o   = mem_q[{2'b01, row_idx_q}];

endmodule

// File: tb/tb_pong_data_memory.sv
// Directed plus randomized bench for pong_data_memory against a behavioural memory/scan model.
module tb_pong_data_memory;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] sw_raw = '0;
  logic [3:0]  row_sel;
  logic [7:0]  col_out;
  logic [7:0]  init_v [16];

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic [7:0]  m [16];
  logic [23:0] sw_hist [2];
  int          edges;

  pong_data_memory_if bus ();

  pong_data_memory #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave),
    .init0_i(init_v[0]),   .init1_i(init_v[1]),   .init2_i(init_v[2]),   .init3_i(init_v[3]),
    .init4_i(init_v[4]),   .init5_i(init_v[5]),   .init6_i(init_v[6]),   .init7_i(init_v[7]),
    .init8_i(init_v[8]),   .init9_i(init_v[9]),   .init10_i(init_v[10]), .init11_i(init_v[11]),
    .init12_i(init_v[12]), .init13_i(init_v[13]), .init14_i(init_v[14]), .init15_i(init_v[15]),
    .sw_raw_i(sw_raw), .row_sel_o(row_sel), .col_out_o(col_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i] = init_v[i];
    sw_hist[0] = '0;
    sw_hist[1] = '0;
    edges = 0;
  endtask

  function automatic logic [3:0] exp_row_sel();
    int r;
    r = (edges / SCAN_DIV) % 4;
    return 4'(1 << r);
  endfunction

  function automatic logic [7:0] exp_col();
    return m[4 + (edges / SCAN_DIV) % 4];
  endfunction

  // One rising edge: model applies the write, then the switch words take the value
  // sampled two edges earlier; inputs are then free to change 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (bus.wr_en && bus.wr_addr <= 4'd12) m[bus.wr_addr] = bus.wr_data;
    m[13] = sw_hist[1][7:0];
    m[14] = sw_hist[1][15:8];
    m[15] = sw_hist[1][23:16];
    sw_hist[1] = sw_hist[0];
    sw_hist[0] = sw_raw;
    edges++;
    #1;
  endtask

  task automatic chk_scan(input string tag);
    chk({tag, "_row"}, 32'(row_sel), 32'(exp_row_sel()));
    chk({tag, "_col"}, 32'(col_out), 32'(exp_col()));
  endtask

  task automatic chk_rd(input string tag, input logic [3:0] a);
    bus.rd_addr = a;
    #1;
    chk(tag, 32'(bus.rd_data), 32'(m[a]));
  endtask

  initial begin
    init_v = '{8'h00, 8'h02, 8'h05, 8'h00, 8'h40, 8'h20, 8'h10, 8'h04,
               8'h00, 8'h08, 8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03};
    bus.rd_addr = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    model_reset();

    // init load while in reset
    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < 16; a++) chk_rd($sformatf("rst_rd%0d", a), 4'(a));
    chk("rst_addr4", 32'(m[4]), 32'h40);
    chk("rst_row", 32'(row_sel), 32'h1);
    chk("rst_col", 32'(col_out), 32'h40);
    rst = 1'b0;
    model_reset();

    // first edge after release: switch words load 0
    step();
    chk_rd("post_rel_sw15", 4'd15);
    chk("post_rel_sw15_zero", 32'(bus.rd_data), 32'h0);

    // write and read-back, then an ignored write to a switch word
    bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 8'hA5;
    step();
    bus.wr_en = 1'b0;
    chk_rd("wr5", 4'd5);
    chk("wr5_val", 32'(bus.rd_data), 32'hA5);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd14; bus.wr_data = 8'hFF;
    step();
    bus.wr_en = 1'b0;
    chk_rd("wr14_ignored", 4'd14);
    chk_scan("s2");

    // switch synchronizer latency
    sw_raw = 24'h030000;
    bus.rd_addr = 4'd15;
    for (int e = 1; e <= 3; e++) begin
      step();
      chk($sformatf("sync_e%0d", e), 32'(bus.rd_data), (e == 3) ? 32'h03 : 32'h00);
    end

    // read-during-write on word 9
    bus.rd_addr = 4'd9; bus.wr_en = 1'b1; bus.wr_addr = 4'd9; bus.wr_data = 8'h7E;
    #1;
    chk("rdw_before", 32'(bus.rd_data), 32'h08);
    step();
    bus.wr_en = 1'b0;
    chk("rdw_after", 32'(bus.rd_data), 32'h7E);

    // scan sequence, with a write to word 6 while row 2 is active
    for (int e = 0; e < 20; e++) begin
      if (exp_row_sel() == 4'b0100 && e > 8 && !bus.wr_en) begin
        bus.wr_en = 1'b1; bus.wr_addr = 4'd6; bus.wr_data = 8'h5C;
        step();
        bus.wr_en = 1'b0;
        chk("scan_wr6_col", 32'(col_out), (exp_row_sel() == 4'b0100) ? 32'h5C : 32'(exp_col()));
        chk("scan_wr6_mem", 32'(m[6]), 32'h5C);
      end else begin
        step();
      end
      chk_scan($sformatf("scan%0d", e));
    end

    // randomized traffic
    for (int c = 0; c < 300; c++) begin
      bus.wr_en   = 1'($urandom_range(0, 1));
      bus.wr_addr = 4'($urandom_range(0, 15));
      bus.wr_data = 8'($urandom);
      sw_raw      = 24'($urandom);
      chk_rd("rnd_rd", 4'($urandom_range(0, 15)));
      chk_scan("rnd_pre");
      step();
      chk_scan("rnd_post");
    end
    bus.wr_en = 1'b0;

    // reset mid-scan after clearing word 4
    bus.wr_en = 1'b1; bus.wr_addr = 4'd4; bus.wr_data = 8'h00;
    step();
    bus.wr_en = 1'b0;
    for (int g = 0; g < 32 && exp_row_sel() != 4'b0100; g++) step();
    chk("pre_rst_row2", 32'(row_sel), 32'h4);
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_row", 32'(row_sel), 32'h1);
    chk("midrst_col", 32'(col_out), 32'h40);
    chk_rd("midrst_mem4", 4'd4);
    chk_rd("midrst_mem15", 4'd15);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      bus.wr_en   = (c > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.wr_addr = 4'($urandom_range(0, 15));
      bus.wr_data = 8'($urandom);
      sw_raw      = 24'($urandom);
      chk_rd("post_rst_rd", 4'($urandom_range(0, 15)));
      step();
      chk_scan("post_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
